// File: rtl/nim_frame_renderer_if.sv
// Game-state update channel between the Nim game logic (master) and the
// frame renderer (slave): a valid/ready handshake carrying one full state.
interface nim_frame_renderer_if #(
  parameter int CNT_W = 4
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [0:3][CNT_W-1:0] pile_cnt;
  logic [1:0]            sel_pile;
  logic                  player;
  logic                  game_over;

  modport master (
    output upd_valid, pile_cnt, sel_pile, player, game_over,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, pile_cnt, sel_pile, player, game_over,
    output upd_ready
  );
endinterface

// File: rtl/nim_frame_renderer.sv
// Renders the Nim board into an 8x8 RGB back buffer one column per cycle and
// publishes it to the front buffer only on a display frame boundary.
module nim_frame_renderer #(
  parameter int NUM_PILES = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nim_frame_renderer_if.slave   upd,
  input  logic [2:0]            i_col_num,
  output logic [0:7][7:0]       o_image_red,
  output logic [0:7][7:0]       o_image_green,
  output logic [0:7][7:0]       o_image_blue,
  output logic                  o_frame_swap
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RENDER    = 2'd1,
    S_WAIT_SYNC = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_upd_ready;
  logic w_accept;
  logic w_rerender;
  logic w_render_we;
  logic w_swap;
  logic w_boundary;
  logic w_blink_wrap;

  logic [2:0]         r_col;
  logic [2:0]         r_col_num_q;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic               r_blink_pending;

  logic [0:3][CNT_W-1:0] r_pile_cnt;
  logic [1:0]            r_sel_pile;
  logic                  r_player;
  logic                  r_game_over;
  logic                  r_render_phase;

  logic [0:7][7:0] r_back_red;
  logic [0:7][7:0] r_back_green;
  logic [0:7][7:0] r_back_blue;
  logic [0:7][7:0] r_front_red;
  logic [0:7][7:0] r_front_green;
  logic [0:7][7:0] r_front_blue;
  logic            r_frame_swap;

  logic [1:0] w_pile;
  logic [7:0] w_mask;
  logic       w_shown;
  logic       w_selected;
  logic [7:0] w_col_red;
  logic [7:0] w_col_green;
  logic [7:0] w_col_blue;

  // Bottom-up bar of stones; any count of 8 or more fills the column.
  function automatic logic [7:0] col_mask(input logic [CNT_W-1:0] cnt);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (int'(cnt) > i);
    end
    return m;
  endfunction

  assign w_boundary   = (r_col_num_q == 3'd7) && (i_col_num == 3'd0);
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_upd_ready = 1'b0;
    w_accept    = 1'b0;
    w_rerender  = 1'b0;
    w_render_we = 1'b0;
    w_swap      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_upd_ready = 1'b1;
        if (upd.upd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RENDER;
        end else if (r_blink_pending) begin
          w_rerender  = 1'b1;
          w_state_nxt = S_RENDER;
        end
      end
      S_RENDER: begin
        w_render_we = 1'b1;
        if (r_col == 3'd7) begin
          w_state_nxt = S_WAIT_SYNC;
        end
      end
      S_WAIT_SYNC: begin
        if (w_boundary) begin
          w_swap      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign upd.upd_ready = w_upd_ready;

  // ---------------------------------------------------------------------------
  // Captured game state and render column index
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pile_cnt     <= '0;
      r_sel_pile     <= '0;
      r_player       <= 1'b0;
      r_game_over    <= 1'b0;
      r_render_phase <= 1'b0;
      r_col          <= '0;
      r_col_num_q    <= '0;
    end else begin
      r_col_num_q <= i_col_num;
      if (w_accept) begin
        r_pile_cnt  <= upd.pile_cnt;
        r_sel_pile  <= upd.sel_pile;
        r_player    <= upd.player;
        r_game_over <= upd.game_over;
      end
      if (w_accept || w_rerender) begin
        r_render_phase <= r_blink_phase;
        r_col          <= '0;
      end else if (w_render_we) begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink divider; a wrap in the same cycle as a render start keeps pending
  // set, so the toggled phase is rendered on the following pass.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt     <= '0;
      r_blink_phase   <= 1'b0;
      r_blink_pending <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      if (w_blink_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
      if (w_blink_wrap && !r_game_over) begin
        r_blink_pending <= 1'b1;
      end else if (w_accept || w_rerender) begin
        r_blink_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Column colouring
  // ---------------------------------------------------------------------------
  assign w_pile     = r_col[2:1];
  assign w_mask     = col_mask(r_pile_cnt[w_pile]);
  assign w_shown    = (int'(w_pile) < NUM_PILES);
  assign w_selected = (w_pile == r_sel_pile);

  always_comb begin
    w_col_red   = '0;
    w_col_green = '0;
    w_col_blue  = '0;
    if (w_shown) begin
      if (r_game_over) begin
        w_col_green = w_mask;
      end else if (w_selected) begin
        w_col_green = r_render_phase ? 8'h00 : w_mask;
      end else if (r_player) begin
        w_col_blue = w_mask;
      end else begin
        w_col_red = w_mask;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Back and front buffers
  // ---------------------------------------------------------------------------
  // NOTE: the buffers are small flop arrays that must read as a blank image
  // straight out of reset, so they are reset like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_back_red    <= '0;
      r_back_green  <= '0;
      r_back_blue   <= '0;
      r_front_red   <= '0;
      r_front_green <= '0;
      r_front_blue  <= '0;
      r_frame_swap  <= 1'b0;
    end else begin
      r_frame_swap <= w_swap;
      if (w_render_we) begin
        r_back_red[r_col]   <= w_col_red;
        r_back_green[r_col] <= w_col_green;
        r_back_blue[r_col]  <= w_col_blue;
      end
      if (w_swap) begin
        r_front_red   <= r_back_red;
        r_front_green <= r_back_green;
        r_front_blue  <= r_back_blue;
      end
    end
  end

  assign o_image_red   = r_front_red;
  assign o_image_green = r_front_green;
  assign o_image_blue  = r_front_blue;
  assign o_frame_swap  = r_frame_swap;

endmodule

// File: tb/tb_nim_frame_renderer.sv
// Scoreboard bench: two renderers (4 and 3 piles) share stimulus; a monitor
// checks every frame_swap against queued hand-computed images.
module tb_nim_frame_renderer;

  localparam int BLINK_DIV = 64;

  // {red, green, blue}, each 64 bits with column 0 in the top byte
  typedef logic [191:0] img_t;

  localparam img_t V1_4  = {64'h0707_0000_FFFF_0000, 64'h0000_0000_0000_1F1F, 64'h0};
  localparam img_t V1_3  = {64'h0707_0000_FFFF_0000, 64'h0,                   64'h0};
  localparam img_t V2A_4 = {64'h0, 64'h0000_0000_FFFF_0000, 64'h0707_0000_0000_1F1F};
  localparam img_t V2B_4 = {64'h0, 64'h0,                   64'h0707_0000_0000_1F1F};
  localparam img_t V2A_3 = {64'h0, 64'h0000_0000_FFFF_0000, 64'h0707_0000_0000_0000};
  localparam img_t V2B_3 = {64'h0, 64'h0,                   64'h0707_0000_0000_0000};
  localparam img_t V3_4  = {64'hFFFF_0000_0303_FFFF, 64'h0000_0101_0000_0000, 64'h0};
  localparam img_t V3_3  = {64'hFFFF_0000_0303_0000, 64'h0000_0101_0000_0000, 64'h0};
  localparam img_t V4_4  = {64'h0, 64'h0101_0303_0707_0F0F, 64'h0};
  localparam img_t V4_3  = {64'h0, 64'h0101_0303_0707_0000, 64'h0};

  logic       clk;
  logic       reset;
  logic [2:0] col_num;
  logic       sweep;

  logic [0:7][7:0] r4, g4, b4, r3, g3, b3;
  logic            swap4, swap3;

  int   n_checks;
  int   n_fail;
  int   cyc;
  img_t exp_q[2][$];
  int   swap_t[$];

  img_t       prev4, prev3;
  logic       prst;
  logic [2:0] h1, h2;

  nim_frame_renderer_if #(.CNT_W(4)) if4 ();
  nim_frame_renderer_if #(.CNT_W(4)) if3 ();

  nim_frame_renderer #(.NUM_PILES(4), .BLINK_DIV(BLINK_DIV), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .upd(if4), .i_col_num(col_num),
    .o_image_red(r4), .o_image_green(g4), .o_image_blue(b4), .o_frame_swap(swap4)
  );

  nim_frame_renderer #(.NUM_PILES(3), .BLINK_DIV(BLINK_DIV), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .upd(if3), .i_col_num(col_num),
    .o_image_red(r3), .o_image_green(g3), .o_image_blue(b3), .o_frame_swap(swap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Display driver model: scans one column per cycle while sweep is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sweep) col_num = col_num + 3'd1;
    end
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic swp, input img_t act, input img_t prev);
    string nm;
    img_t  e;
    nm = (d == 0) ? "dut4" : "dut3";
    if (swp) begin
      if (exp_q[d].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_swap_%s: got image %h with nothing expected", nm, act);
      end else begin
        e = exp_q[d].pop_front();
        check({"swap_image_", nm}, act, e);
      end
    end else begin
      check({"image_held_", nm}, act, prev);
    end
  endtask

  // Monitor: every swap must match the next queued image and follow a 7->0
  // column wrap; outside swaps the front buffer must not move.
  initial begin
    prst = 1'b1;
    h1   = '0;
    h2   = '0;
    forever begin
      @(negedge clk);
      if (!reset && !prst) begin
        mon(0, swap4, {r4, g4, b4}, prev4);
        mon(1, swap3, {r3, g3, b3}, prev3);
        if (swap4) begin
          swap_t.push_back(cyc);
          check("swap_after_boundary", 192'({h2, h1}), 192'({3'd7, 3'd0}));
        end
      end
      prev4 = {r4, g4, b4};
      prev3 = {r3, g3, b3};
      prst  = reset;
      h2    = h1;
      h1    = col_num;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [15:0] cnt, input logic [1:0] sel, input logic ply,
                      input logic go, input img_t e4, input img_t e3);
    bit ok;
    ok = 1'b0;
    exp_q[0].push_back(e4);
    exp_q[1].push_back(e3);
    @(posedge clk);
    #1;
    if4.pile_cnt = cnt; if4.sel_pile = sel; if4.player = ply; if4.game_over = go;
    if3.pile_cnt = cnt; if3.sel_pile = sel; if3.player = ply; if3.game_over = go;
    if4.upd_valid = 1'b1;
    if3.upd_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (if4.upd_ready && if3.upd_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if4.upd_valid = 1'b0;
    if3.upd_valid = 1'b0;
    check("upd_accepted", 192'(ok), 192'(1));
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && (exp_q[0].size() + exp_q[1].size()) != 0; i++) begin
      @(negedge clk);
    end
    check({"drain_", name}, 192'(exp_q[0].size() + exp_q[1].size()), 192'(0));
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  task automatic check_blank(input string name);
    check({name, "_img4"}, {r4, g4, b4}, '0);
    check({name, "_img3"}, {r3, g3, b3}, '0);
    check({name, "_ready"}, 192'({if4.upd_ready, if3.upd_ready}), 192'(2'b11));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    col_num  = '0;
    sweep    = 1'b1;
    if4.upd_valid = 1'b0; if4.pile_cnt = '0; if4.sel_pile = '0; if4.player = 1'b0; if4.game_over = 1'b0;
    if3.upd_valid = 1'b0; if3.pile_cnt = '0; if3.sel_pile = '0; if3.player = 1'b0; if3.game_over = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state under a running column scan
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      check_blank("reset_state");
    end

    // Player 0, pile 3 selected, phase 0
    send({4'd3, 4'd0, 4'd8, 4'd5}, 2'd3, 1'b0, 1'b0, V1_4, V1_3);
    wait_empty("v1", 40);
    @(negedge clk);
    check("ready_after_swap", 192'({if4.upd_ready, if3.upd_ready}), 192'(2'b11));
    do_reset();

    // Player 1, pile 2 selected: blink alternates FF / 00 on pile 2
    swap_t.delete();
    send({4'd3, 4'd0, 4'd8, 4'd5}, 2'd2, 1'b1, 1'b0, V2A_4, V2A_3);
    exp_q[0].push_back(V2B_4); exp_q[1].push_back(V2B_3);
    exp_q[0].push_back(V2A_4); exp_q[1].push_back(V2A_3);
    wait_empty("blink", 250);
    check("blink_swap_count", 192'(swap_t.size()), 192'(3));
    if (swap_t.size() >= 3) begin
      check("blink_period", 192'(swap_t[2] - swap_t[1]), 192'(BLINK_DIV));
    end
    do_reset();

    // Saturated counts (12, 15) and a 1-stone selected pile
    send({4'd12, 4'd1, 4'd2, 4'd15}, 2'd1, 1'b0, 1'b0, V3_4, V3_3);
    wait_empty("saturate", 40);
    do_reset();

    // Game over: green only, no blink re-renders across two wraps
    send({4'd1, 4'd2, 4'd3, 4'd4}, 2'd0, 1'b1, 1'b1, V4_4, V4_3);
    wait_empty("game_over", 40);
    repeat (140) @(negedge clk);
    check("game_over_idle_ready", 192'({if4.upd_ready, if3.upd_ready}), 192'(2'b11));
    do_reset();

    // col_num held at 3: render waits, image stays; release 7 -> 0 swaps
    send({4'd12, 4'd1, 4'd2, 4'd15}, 2'd1, 1'b0, 1'b0, V3_4, V3_3);
    wait_empty("pre_hold", 40);
    @(posedge clk);
    #1;
    sweep   = 1'b0;
    col_num = 3'd3;
    send({4'd3, 4'd0, 4'd8, 4'd5}, 2'd3, 1'b0, 1'b0, V1_4, V1_3);
    repeat (12) @(negedge clk);
    check("hold_ready", 192'({if4.upd_ready, if3.upd_ready}), 192'(2'b00));
    check("hold_img4", {r4, g4, b4}, V3_4);
    check("hold_img3", {r3, g3, b3}, V3_3);
    @(posedge clk);
    #1;
    col_num = 3'd7;
    @(posedge clk);
    #1;
    sweep = 1'b1;
    wait_empty("release", 20);
    do_reset();

    // Reset while in WAIT_SYNC
    send({4'd3, 4'd0, 4'd8, 4'd5}, 2'd3, 1'b0, 1'b0, V1_4, V1_3);
    wait_empty("pre_wait_rst", 40);
    @(posedge clk);
    #1;
    sweep   = 1'b0;
    col_num = 3'd3;
    send({4'd1, 4'd2, 4'd3, 4'd4}, 2'd0, 1'b1, 1'b1, V4_4, V4_3);
    repeat (12) @(negedge clk);
    check("wait_sync_ready", 192'({if4.upd_ready, if3.upd_ready}), 192'(2'b00));
    do_reset();
    @(negedge clk);
    check_blank("rst_in_wait");
    sweep = 1'b1;
    send({4'd12, 4'd1, 4'd2, 4'd15}, 2'd1, 1'b0, 1'b0, V3_4, V3_3);
    wait_empty("after_wait_rst", 40);
    do_reset();

    // Reset while in RENDER
    send({4'd3, 4'd0, 4'd8, 4'd5}, 2'd3, 1'b0, 1'b0, V1_4, V1_3);
    wait_empty("pre_render_rst", 40);
    send({4'd3, 4'd0, 4'd8, 4'd5}, 2'd2, 1'b1, 1'b0, V2A_4, V2A_3);
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    check_blank("rst_in_render");
    send({4'd1, 4'd2, 4'd3, 4'd4}, 2'd0, 1'b1, 1'b1, V4_4, V4_3);
    wait_empty("after_render_rst", 40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
